sys_cmd_ctrl: RTL and testbench
===============================

Name: sys_cmd_ctrl

Overview:
- Command-frame decoder in the REF_CLK domain, directly downstream of the RX data synchronizer.
- Consumes synchronized RX bytes (each with a one-cycle valid pulse) and assembles multi-byte command frames.
- Issues register-file write/read and ALU operations, and controls the ALU clock-gate enable.
- Pushes response bytes (read data, ALU result) into the TX async FIFO.

Parameters:
- WIDTH, 8, data/byte width.
- ADDR_WIDTH, 4, register-file address width; lower ADDR_WIDTH bits of the address byte are used.
- TIMEOUT_CYCLES, 4096, inter-byte timeout in CLK cycles (only with CMD_TIMEOUT_EN).

Ports:
- CLK  in  1  REF_CLK domain clock.
- RST  in  1  asynchronous, active-low reset.
- RX_P_DATA  in  WIDTH  synchronized RX byte.
- RX_D_VLD  in  1  one-cycle pulse: RX_P_DATA valid.
- RF_RdData  in  WIDTH  register-file read data.
- RF_RdData_VLD  in  1  read data valid, one-cycle pulse.
- ALU_OUT  in  2*WIDTH  ALU result.
- ALU_OUT_VLD  in  1  ALU result valid, one-cycle pulse.
- FIFO_FULL  in  1  TX FIFO full.
- RF_WrEn  out  1  register-file write strobe.
- RF_RdEn  out  1  register-file read strobe.
- RF_Address  out  ADDR_WIDTH  register-file address.
- RF_WrData  out  WIDTH  register-file write data.
- ALU_EN  out  1  ALU start strobe.
- ALU_FUN  out  4  ALU function code.
- Gate_EN  out  1  ALU clock-gate enable.
- TX_P_DATA  out  WIDTH  byte pushed to the TX FIFO.
- TX_D_VLD  out  1  TX FIFO write strobe.

Behaviour:
- Reset: all outputs are 0 and the FSM is in IDLE. Reset is asynchronous, active-low, on RST; the block is clocked by CLK.
- All outputs are registered. Strobes (RF_WrEn, RF_RdEn, ALU_EN, TX_D_VLD) are exactly one cycle wide.
- A byte is consumed only on a cycle with RX_D_VLD=1. Bytes arriving in any WAIT or TX state are dropped.
- Opcodes: 0xAA = RF write (addr, data); 0xBB = RF read (addr); 0xCC = ALU with operands (OPA, OPB, FUN); 0xDD = ALU without operands (FUN).
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_OPA, ALU_OPB, ALU_FUN, ALU_WAIT, TX_RD, TX_LSB, TX_MSB.
- IDLE: opcode 0xAA -> WR_ADDR, 0xBB -> RD_ADDR, 0xCC -> ALU_OPA, 0xDD -> ALU_FUN. Any other value is ignored and the FSM stays in IDLE.
- WR_ADDR: latch the address -> WR_DATA.
- WR_DATA: on the data byte, RF_WrEn=1 the next cycle with the latched address/data -> IDLE.
- RD_ADDR: on the address byte, RF_RdEn=1 the next cycle -> RD_WAIT.
- RD_WAIT: on RF_RdData_VLD, capture RF_RdData -> TX_RD.
- ALU_OPA: byte is written to RF address 0 (RF_WrEn pulse) -> ALU_OPB.
- ALU_OPB: byte is written to RF address 1 -> ALU_FUN.
- ALU_FUN: Gate_EN=1 from entry into ALU_FUN until the cycle after ALU_OUT_VLD. On the FUN byte, ALU_FUN=byte[3:0] and ALU_EN=1 the next cycle -> ALU_WAIT.
- ALU_WAIT: on ALU_OUT_VLD, capture the result -> TX_LSB.
- TX_RD / TX_LSB / TX_MSB: hold while FIFO_FULL=1. When FIFO_FULL=0, TX_D_VLD=1 with the byte. Order is result[WIDTH-1:0] then result[2*WIDTH-1:WIDTH]. TX_RD and TX_MSB -> IDLE; TX_LSB -> TX_MSB.
- ALU_FUN, ALU_EN and ALU_OUT_VLD coincident with an RX byte: the RX byte is dropped.
- Latency: last frame byte to strobe is 1 cycle. Result valid to TX_D_VLD is 1 cycle when the FIFO is not full.
- Reset mid-frame: FSM returns to IDLE, partial frame discarded, Gate_EN deasserted.

Optional Feature:
- Macro: CMD_TIMEOUT_EN.
- Defined: an inter-byte counter runs in WR_ADDR, WR_DATA, RD_ADDR, ALU_OPA, ALU_OPB and ALU_FUN, and clears on each RX_D_VLD. Reaching TIMEOUT_CYCLES forces IDLE with no strobe issued and Gate_EN=0.
- Undefined: no counter; the FSM waits indefinitely for the next frame byte.

Decomposition:
- Shared package/macros file: WIDTH, ADDR_WIDTH, opcode constants (CMD_RF_WR, CMD_RF_RD, CMD_ALU_OP, CMD_ALU_NOP), RF operand addresses (OPA_ADDR=0, OPB_ADDR=1), FSM state encoding.
- One natural sub-module: cmd_timeout_cnt, instantiated only under CMD_TIMEOUT_EN.

Test Plan:
- AA,05,3C as RX pulses -> single RF_WrEn with RF_Address=5, RF_WrData=0x3C; FSM back in IDLE.
- BB,07; RF_RdData=0x5A with VLD 2 cycles after RF_RdEn -> one TX_D_VLD with TX_P_DATA=0x5A.
- CC,0A,14,00; ALU_OUT=0x001E -> RF writes addr0=0x0A, addr1=0x14; ALU_EN with ALU_FUN=0; TX 0x1E then 0x00; Gate_EN high from the 3rd byte until result valid.
- DD,02 with FIFO_FULL=1 for 10 cycles after ALU_OUT_VLD -> no TX_D_VLD while full; LSB then MSB pushed after FULL drops.
- 0x55 then AA,01,FF -> 0x55 ignored; write addr1=0xFF performed.
- AA,03, RST low, then AA,03,11 -> no write before reset; a single write addr3=0x11 after. With CMD_TIMEOUT_EN: AA, then a gap of TIMEOUT_CYCLES -> return to IDLE, no strobe.

Source files
------------

// File: rtl/sys_cmd_ctrl_pkg.sv
// Shared definitions for the command-frame decoder: default widths, command
// opcodes, operand register addresses and the FSM state encoding.
package sys_cmd_ctrl_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  // Command opcodes (first byte of every frame)
  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  // Register-file locations that receive the ALU operands
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_ALU_OPA,
    ST_ALU_OPB,
    ST_ALU_FUN,
    ST_ALU_WAIT,
    ST_TX_RD,
    ST_TX_LSB,
    ST_TX_MSB
  } state_e;

  // States in which the decoder is waiting for the next byte of a frame
  function automatic logic is_byte_wait(input state_e s);
    return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) ||
           (s == ST_ALU_OPA) || (s == ST_ALU_OPB) || (s == ST_ALU_FUN);
  endfunction

endpackage

// File: rtl/sys_cmd_ctrl_timeout.sv
// Inter-byte timeout counter. Counts cycles while the decoder waits for a
// frame byte, restarts on every received byte, and flags the cycle on which
// TIMEOUT_CYCLES idle cycles have elapsed. Used only with CMD_TIMEOUT_EN.
module cmd_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_reg;

  // Idle-cycle counter, held at zero outside the byte-wait states
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_reg <= '0;
    end else if (!run || clr) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expired = run && !clr && (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command-frame decoder (REF_CLK domain). Assembles RX bytes into register
// write/read and ALU frames, issues one-cycle strobes, drives the ALU clock
// gate and pushes responses into the TX FIFO. All outputs are registered.
// Optional build macro: CMD_TIMEOUT_EN (inter-byte timeout back to IDLE).
module sys_cmd_ctrl
  import sys_cmd_ctrl_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [WIDTH-1:0]      RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic [WIDTH-1:0]      RF_RdData,
  input  logic                  RF_RdData_VLD,
  input  logic [2*WIDTH-1:0]    ALU_OUT,
  input  logic                  ALU_OUT_VLD,
  input  logic                  FIFO_FULL,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [WIDTH-1:0]      RF_WrData,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  Gate_EN,
  output logic [WIDTH-1:0]      TX_P_DATA,
  output logic                  TX_D_VLD
);

  state_e                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [2*WIDTH-1:0]    result_reg, result_next;

  logic                  rf_wr_en_reg, rf_wr_en_next;
  logic                  rf_rd_en_reg, rf_rd_en_next;
  logic [ADDR_WIDTH-1:0] rf_address_reg, rf_address_next;
  logic [WIDTH-1:0]      rf_wr_data_reg, rf_wr_data_next;
  logic                  alu_en_reg, alu_en_next;
  logic [3:0]            alu_fun_reg, alu_fun_next;
  logic                  gate_en_reg, gate_en_next;
  logic [WIDTH-1:0]      tx_p_data_reg, tx_p_data_next;
  logic                  tx_d_vld_reg, tx_d_vld_next;

  logic                  timeout_hit;

`ifdef CMD_TIMEOUT_EN
  cmd_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .CLK     (CLK),
    .RST     (RST),
    .run     (is_byte_wait(state_reg)),
    .clr     (RX_D_VLD),
    .expired (timeout_hit)
  );
`else
  // Without the timeout the decoder waits indefinitely for the next byte
  assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // State and registered-output update
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      result_reg     <= '0;
      rf_wr_en_reg   <= 1'b0;
      rf_rd_en_reg   <= 1'b0;
      rf_address_reg <= '0;
      rf_wr_data_reg <= '0;
      alu_en_reg     <= 1'b0;
      alu_fun_reg    <= '0;
      gate_en_reg    <= 1'b0;
      tx_p_data_reg  <= '0;
      tx_d_vld_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      result_reg     <= result_next;
      rf_wr_en_reg   <= rf_wr_en_next;
      rf_rd_en_reg   <= rf_rd_en_next;
      rf_address_reg <= rf_address_next;
      rf_wr_data_reg <= rf_wr_data_next;
      alu_en_reg     <= alu_en_next;
      alu_fun_reg    <= alu_fun_next;
      gate_en_reg    <= gate_en_next;
      tx_p_data_reg  <= tx_p_data_next;
      tx_d_vld_reg   <= tx_d_vld_next;
    end
  end

  // Next-state and next-output decode. When a response arrives and the FIFO
  // has room, the first byte is pushed straight away so the push lands one
  // cycle after the valid pulse; the TX_RD/TX_LSB states then only hold a
  // byte that was blocked by FIFO_FULL.
  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    result_next     = result_reg;
    rf_wr_en_next   = 1'b0;
    rf_rd_en_next   = 1'b0;
    rf_address_next = rf_address_reg;
    rf_wr_data_next = rf_wr_data_reg;
    alu_en_next     = 1'b0;
    alu_fun_next    = alu_fun_reg;
    tx_p_data_next  = tx_p_data_reg;
    tx_d_vld_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WIDTH'(CMD_RF_WR)) begin
            state_next = ST_WR_ADDR;
          end else if (RX_P_DATA == WIDTH'(CMD_RF_RD)) begin
            state_next = ST_RD_ADDR;
          end else if (RX_P_DATA == WIDTH'(CMD_ALU_OP)) begin
            state_next = ST_ALU_OPA;
          end else if (RX_P_DATA == WIDTH'(CMD_ALU_NOP)) begin
            state_next = ST_ALU_FUN;
          end
        end
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_next  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_next = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          rf_wr_en_next   = 1'b1;
          rf_address_next = addr_reg;
          rf_wr_data_next = RX_P_DATA;
          state_next      = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          rf_rd_en_next   = 1'b1;
          rf_address_next = RX_P_DATA[ADDR_WIDTH-1:0];
          state_next      = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (RF_RdData_VLD) begin
          result_next = {{WIDTH{1'b0}}, RF_RdData};
          if (!FIFO_FULL) begin
            tx_d_vld_next  = 1'b1;
            tx_p_data_next = RF_RdData;
            state_next     = ST_IDLE;
          end else begin
            state_next = ST_TX_RD;
          end
        end
      end
      ST_ALU_OPA: begin
        if (RX_D_VLD) begin
          rf_wr_en_next   = 1'b1;
          rf_address_next = ADDR_WIDTH'(OPA_ADDR);
          rf_wr_data_next = RX_P_DATA;
          state_next      = ST_ALU_OPB;
        end
      end
      ST_ALU_OPB: begin
        if (RX_D_VLD) begin
          rf_wr_en_next   = 1'b1;
          rf_address_next = ADDR_WIDTH'(OPB_ADDR);
          rf_wr_data_next = RX_P_DATA;
          state_next      = ST_ALU_FUN;
        end
      end
      ST_ALU_FUN: begin
        if (RX_D_VLD) begin
          alu_en_next  = 1'b1;
          alu_fun_next = RX_P_DATA[3:0];
          state_next   = ST_ALU_WAIT;
        end
      end
      ST_ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          result_next = ALU_OUT;
          if (!FIFO_FULL) begin
            tx_d_vld_next  = 1'b1;
            tx_p_data_next = ALU_OUT[WIDTH-1:0];
            state_next     = ST_TX_MSB;
          end else begin
            state_next = ST_TX_LSB;
          end
        end
      end
      ST_TX_RD: begin
        if (!FIFO_FULL) begin
          tx_d_vld_next  = 1'b1;
          tx_p_data_next = result_reg[WIDTH-1:0];
          state_next     = ST_IDLE;
        end
      end
      ST_TX_LSB: begin
        if (!FIFO_FULL) begin
          tx_d_vld_next  = 1'b1;
          tx_p_data_next = result_reg[WIDTH-1:0];
          state_next     = ST_TX_MSB;
        end
      end
      ST_TX_MSB: begin
        if (!FIFO_FULL) begin
          tx_d_vld_next  = 1'b1;
          tx_p_data_next = result_reg[2*WIDTH-1:WIDTH];
          state_next     = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A timeout only fires in byte-wait states on cycles with no byte, so no
    // strobe has been requested above when it overrides the next state.
    if (timeout_hit) begin
      state_next = ST_IDLE;
    end

    // Clock gate open while an ALU function byte or result is outstanding
    gate_en_next = (state_next == ST_ALU_FUN) || (state_next == ST_ALU_WAIT);
  end

  assign RF_WrEn    = rf_wr_en_reg;
  assign RF_RdEn    = rf_rd_en_reg;
  assign RF_Address = rf_address_reg;
  assign RF_WrData  = rf_wr_data_reg;
  assign ALU_EN     = alu_en_reg;
  assign ALU_FUN    = alu_fun_reg;
  assign Gate_EN    = gate_en_reg;
  assign TX_P_DATA  = tx_p_data_reg;
  assign TX_D_VLD   = tx_d_vld_reg;

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Testbench for sys_cmd_ctrl: frame-level reference model checked every
// cycle, plus literal expectations on the logged DUT transactions.
module tb_sys_cmd_ctrl;

  localparam int TO = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  RF_RdData = '0;
  logic        RF_RdData_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic        RF_WrEn, RF_RdEn, ALU_EN, Gate_EN, TX_D_VLD;
  logic [3:0]  RF_Address, ALU_FUN;
  logic [7:0]  RF_WrData, TX_P_DATA;

  sys_cmd_ctrl #(.WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .FIFO_FULL(FIFO_FULL),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .Gate_EN(Gate_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Logs of what the DUT actually issued
  int wr_log[$];   // (addr << 8) | data
  int rd_log[$];
  int alu_log[$];
  int tx_log[$];

  // Reference model state: bytes of the frame in progress, outstanding
  // response, and response bytes not yet accepted by the FIFO
  logic [7:0] frame[$];
  logic [7:0] txq[$];
  bit         wait_rd, wait_alu;
  int         idle_cnt;
  bit         e_wr, e_rd, e_alu, e_tx, e_gate;
  logic [3:0] e_addr, e_fun;
  logic [7:0] e_wdata, e_txd;

  task automatic model_reset();
    frame.delete(); txq.delete();
    wait_rd = 0; wait_alu = 0; idle_cnt = 0;
    e_wr = 0; e_rd = 0; e_alu = 0; e_tx = 0; e_gate = 0;
  endtask

  task automatic accept_byte(input logic [7:0] b);
    logic [7:0] x;
    if (frame.size() == 0 && !(b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD})) return;
    frame.push_back(b);
    case (frame[0])
      8'hAA: if (frame.size() == 3) begin
        x = frame[1]; e_wr = 1; e_addr = x[3:0]; e_wdata = frame[2]; frame.delete();
      end
      8'hBB: if (frame.size() == 2) begin
        x = frame[1]; e_rd = 1; e_addr = x[3:0]; wait_rd = 1; frame.delete();
      end
      8'hCC: begin
        if (frame.size() == 2) begin e_wr = 1; e_addr = 4'd0; e_wdata = frame[1]; end
        else if (frame.size() == 3) begin e_wr = 1; e_addr = 4'd1; e_wdata = frame[2]; end
        else if (frame.size() == 4) begin
          x = frame[3]; e_alu = 1; e_fun = x[3:0]; wait_alu = 1; frame.delete();
        end
      end
      default: if (frame.size() == 2) begin
        x = frame[1]; e_alu = 1; e_fun = x[3:0]; wait_alu = 1; frame.delete();
      end
    endcase
  endtask

  // Advance the model by one clock using the inputs the DUT will sample
  task automatic model_step();
    bit busy;
    e_wr = 0; e_rd = 0; e_alu = 0; e_tx = 0;
    busy = wait_rd || wait_alu || (txq.size() != 0);
    if (wait_rd && RF_RdData_VLD) begin
      wait_rd = 0; txq.push_back(RF_RdData);
    end else if (wait_alu && ALU_OUT_VLD) begin
      wait_alu = 0; txq.push_back(ALU_OUT[7:0]); txq.push_back(ALU_OUT[15:8]);
    end else if (!busy && RX_D_VLD) begin
      accept_byte(RX_P_DATA);
    end
`ifdef CMD_TIMEOUT_EN
    if (!busy && frame.size() != 0 && !RX_D_VLD) begin
      idle_cnt++;
      if (idle_cnt == TO) begin frame.delete(); idle_cnt = 0; end
    end else begin
      idle_cnt = 0;
    end
`endif
    if (txq.size() != 0 && !FIFO_FULL) begin e_tx = 1; e_txd = txq.pop_front(); end
    e_gate = wait_alu || (frame.size() != 0 &&
             ((frame[0] == 8'hCC && frame.size() == 3) || frame[0] == 8'hDD));
  endtask

  // Per-cycle compare against the model, on the falling edge
  initial begin
    model_reset();
    forever begin
      @(negedge CLK);
      if (!RST) model_reset();
      check("rf_wr_en", RF_WrEn, e_wr);
      check("rf_rd_en", RF_RdEn, e_rd);
      check("alu_en", ALU_EN, e_alu);
      check("tx_d_vld", TX_D_VLD, e_tx);
      check("gate_en", Gate_EN, e_gate);
      if (e_wr || e_rd) check("rf_address", RF_Address, e_addr);
      if (e_wr) check("rf_wr_data", RF_WrData, e_wdata);
      if (e_alu) check("alu_fun", ALU_FUN, e_fun);
      if (e_tx) check("tx_p_data", TX_P_DATA, e_txd);
      if (RF_WrEn) begin
        wr_log.push_back((int'(RF_Address) << 8) | int'(RF_WrData));
        $display("wr  addr=%0d data=0x%02h", RF_Address, RF_WrData);
      end
      if (RF_RdEn) begin rd_log.push_back(RF_Address); $display("rd  addr=%0d", RF_Address); end
      if (ALU_EN) begin alu_log.push_back(ALU_FUN); $display("alu fun=%0d", ALU_FUN); end
      if (TX_D_VLD) begin tx_log.push_back(TX_P_DATA); $display("tx  data=0x%02h", TX_P_DATA); end
      if (RST) model_step();
    end
  end

  task automatic tick(); @(posedge CLK); #1; endtask
  task automatic gap(); tick(); endtask
  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b; RX_D_VLD = 1'b1; tick(); RX_D_VLD = 1'b0;
  endtask
  task automatic clear_logs();
    wr_log.delete(); rd_log.delete(); alu_log.delete(); tx_log.delete();
  endtask
  // which: 0 = RF_RdEn, 1 = ALU_EN; bounded wait
  task automatic wait_strobe(input int which, input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if ((which == 0 && RF_RdEn) || (which == 1 && ALU_EN)) seen = 1;
      else tick();
    end
    check(name, seen, 1);
  endtask
  task automatic alu_result(input logic [15:0] r, input int full_cycles);
    tick(); tick();
    ALU_OUT = r; ALU_OUT_VLD = 1'b1; FIFO_FULL = (full_cycles > 0);
    tick();
    ALU_OUT_VLD = 1'b0;
    for (int i = 1; i < full_cycles; i++) tick();
    FIFO_FULL = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("reset_wr_en", RF_WrEn, 0);
    check("reset_gate", Gate_EN, 0);
    check("reset_tx_vld", TX_D_VLD, 0);
    RST = 1'b1;
    tick();

    // 1: register write AA,05,3C
    clear_logs();
    send_byte(8'hAA); gap(); send_byte(8'h05); gap(); send_byte(8'h3C);
    repeat (4) tick();
    check("t1_wr_count", wr_log.size(), 1);
    if (wr_log.size() > 0) check("t1_wr", wr_log[0], 'h53C);

    // 2: register read BB,07, byte during RD_WAIT dropped, data 2 cycles later
    clear_logs();
    send_byte(8'hBB); gap(); send_byte(8'h07);
    wait_strobe(0, "t2_rd_en_seen");
    send_byte(8'hAA);
    tick();
    RF_RdData = 8'h5A; RF_RdData_VLD = 1'b1; tick(); RF_RdData_VLD = 1'b0;
    repeat (4) tick();
    check("t2_rd_count", rd_log.size(), 1);
    if (rd_log.size() > 0) check("t2_rd_addr", rd_log[0], 7);
    check("t2_tx_count", tx_log.size(), 1);
    if (tx_log.size() > 0) check("t2_tx", tx_log[0], 'h5A);
    check("t2_no_wr", wr_log.size(), 0);

    // 3: ALU with operands CC,0A,14,00 -> 0x001E
    clear_logs();
    send_byte(8'hCC); gap(); send_byte(8'h0A); gap(); send_byte(8'h14);
    check("t3_gate_after_opb", Gate_EN, 1);
    gap(); send_byte(8'h00);
    wait_strobe(1, "t3_alu_en_seen");
    check("t3_gate_at_alu_en", Gate_EN, 1);
    alu_result(16'h001E, 0);
    check("t3_gate_after_result", Gate_EN, 0);
    repeat (4) tick();
    check("t3_wr_count", wr_log.size(), 2);
    if (wr_log.size() > 1) begin
      check("t3_wr_opa", wr_log[0], 'h00A);
      check("t3_wr_opb", wr_log[1], 'h114);
    end
    check("t3_alu_count", alu_log.size(), 1);
    if (alu_log.size() > 0) check("t3_alu_fun", alu_log[0], 0);
    check("t3_tx_count", tx_log.size(), 2);
    if (tx_log.size() > 1) begin
      check("t3_tx_lsb", tx_log[0], 'h1E);
      check("t3_tx_msb", tx_log[1], 'h00);
    end

    // 4: ALU without operands DD,02 with FIFO full for 10 cycles
    clear_logs();
    send_byte(8'hDD);
    check("t4_gate_after_op", Gate_EN, 1);
    gap(); send_byte(8'h02);
    wait_strobe(1, "t4_alu_en_seen");
    alu_result(16'hA55B, 10);
    check("t4_tx_while_full", tx_log.size(), 0);
    repeat (4) tick();
    check("t4_tx_count", tx_log.size(), 2);
    if (tx_log.size() > 1) begin
      check("t4_tx_lsb", tx_log[0], 'h5B);
      check("t4_tx_msb", tx_log[1], 'hA5);
    end
    if (alu_log.size() > 0) check("t4_alu_fun", alu_log[0], 2);

    // 5: unknown opcode ignored, then AA,01,FF
    clear_logs();
    send_byte(8'h55); gap(); send_byte(8'hAA); gap(); send_byte(8'h01); gap(); send_byte(8'hFF);
    repeat (4) tick();
    check("t5_wr_count", wr_log.size(), 1);
    if (wr_log.size() > 0) check("t5_wr", wr_log[0], 'h1FF);

    // 6: reset mid-frame, then a full write
    clear_logs();
    send_byte(8'hAA); gap(); send_byte(8'h03); gap();
    RST = 1'b0; tick(); tick();
    check("t6_reset_no_wr", wr_log.size(), 0);
    RST = 1'b1; tick();
    send_byte(8'hAA); gap(); send_byte(8'h03); gap(); send_byte(8'h11);
    repeat (4) tick();
    check("t6_wr_count", wr_log.size(), 1);
    if (wr_log.size() > 0) check("t6_wr", wr_log[0], 'h311);

`ifdef CMD_TIMEOUT_EN
    // 7: timeout after a lone opcode, then a fresh frame decodes normally
    clear_logs();
    send_byte(8'hAA);
    repeat (TO + 4) tick();
    check("t7_timeout_no_wr", wr_log.size(), 0);
    send_byte(8'hAA); gap(); send_byte(8'h02); gap(); send_byte(8'h33);
    repeat (4) tick();
    check("t7_wr_count", wr_log.size(), 1);
    if (wr_log.size() > 0) check("t7_wr", wr_log[0], 'h233);
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
